// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core
// load/store port and a DMA/debug port, routing read data back by owner.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   core_req/we/addr/wdata/mask     core request bundle (held until core_gnt)
//   core_gnt, core_stall            core issued / core waiting this cycle
//   core_rvalid, core_rdata         core load return (cycle after grant)
//   dma_req/we/addr/wdata/mask      DMA request bundle (same rules as core)
//   dma_gnt, dma_rvalid, dma_rdata  DMA grant and load return
//   mem_addr/wdata/memread/memwrite/sign_mask  strobes to data_mem
//   mem_rdata                       data_mem read data (cycle after memread)
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_mask,
    output logic        core_gnt,
    output logic        core_stall,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_mask,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        RD_NONE,
        RD_CORE,
        RD_DMA
    } rd_owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       dma_win;
    logic       core_win;
    logic [3:0] starve_cnt;
    rd_owner_e  rd_owner;
    rd_owner_e  rd_owner_nxt;

    // Core has priority unless DMA has waited LIMIT contested grants.
    assign dma_win  = dma_req & (~core_req | (starve_cnt == LIMIT));
    assign core_win = core_req & ~dma_win;

    assign core_gnt   = core_win;
    assign dma_gnt    = dma_win;
    assign core_stall = core_req & ~core_win;

    always_comb begin
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_memread   = 1'b0;
        mem_memwrite  = 1'b0;
        mem_sign_mask = '0;
        unique case (1'b1)
            core_win: begin
                mem_addr      = core_addr;
                mem_wdata     = core_wdata;
                mem_memread   = ~core_we;
                mem_memwrite  = core_we;
                mem_sign_mask = core_mask;
            end
            dma_win: begin
                mem_addr      = dma_addr;
                mem_wdata     = dma_wdata;
                mem_memread   = ~dma_we;
                mem_memwrite  = dma_we;
                mem_sign_mask = dma_mask;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (dma_win | ~dma_req) begin
            starve_cnt <= '0;
        end else if (core_win && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner <= RD_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    always_comb begin
        rd_owner_nxt = RD_NONE;
        unique case (1'b1)
            core_win & ~core_we: rd_owner_nxt = RD_CORE;
            dma_win & ~dma_we:   rd_owner_nxt = RD_DMA;
            default:             rd_owner_nxt = RD_NONE;
        endcase
    end

    // Return data is gated so a port never sees the other port's read.
    assign core_rvalid = (rd_owner == RD_CORE);
    assign dma_rvalid  = (rd_owner == RD_DMA);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign dma_rdata   = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter
// with a small word-wide sync-read memory standing in for data_mem.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_mask;
    logic        core_gnt;
    logic        core_stall;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_mask;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_rdata;

    logic [31:0] mem [16];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_mask    (core_mask),
        .core_gnt     (core_gnt),
        .core_stall   (core_stall),
        .core_rvalid  (core_rvalid),
        .core_rdata   (core_rdata),
        .dma_req      (dma_req),
        .dma_we       (dma_we),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .dma_mask     (dma_mask),
        .dma_gnt      (dma_gnt),
        .dma_rvalid   (dma_rvalid),
        .dma_rdata    (dma_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .mem_sign_mask(mem_sign_mask),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 | i;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_memwrite) mem[mem_addr[5:2]] <= mem_wdata;
        if (mem_memread)  mem_rdata <= mem[mem_addr[5:2]];
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic core_set(input logic req, input logic we,
                            input logic [31:0] addr,
                            input logic [31:0] wdata,
                            input logic [3:0] mask);
        core_req   = req;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wdata;
        core_mask  = mask;
    endtask

    task automatic dma_set(input logic req, input logic we,
                           input logic [31:0] addr,
                           input logic [31:0] wdata,
                           input logic [3:0] mask);
        dma_req   = req;
        dma_we    = we;
        dma_addr  = addr;
        dma_wdata = wdata;
        dma_mask  = mask;
    endtask

    initial begin
        int prev;
        logic exp_d;

        rst_n = 1'b0;
        core_set(1'b1, 1'b0, 32'h1000, 32'h0, 4'b0010);
        dma_set(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);

        // 1: reset with a pending core load
        repeat (2) @(negedge clk);
        #1;
        chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_core_gnt", 32'(core_gnt), 32'd1);
        chk("rel_memread", 32'(mem_memread), 32'd1);
        chk("rel_mem_addr", mem_addr, 32'h1000);
        @(negedge clk);
        core_set(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        #1;
        chk("rel_core_rvalid", 32'(core_rvalid), 32'd1);
        chk("rel_core_rdata", core_rdata, 32'hA000_0000);

        // 2: core alone
        @(negedge clk);
        core_set(1'b1, 1'b0, 32'h1004, 32'h0, 4'b0100);
        #1;
        chk("c2_gnt", 32'(core_gnt), 32'd1);
        chk("c2_stall", 32'(core_stall), 32'd0);
        chk("c2_mem_addr", mem_addr, 32'h1004);
        chk("c2_mask", 32'(mem_sign_mask), 32'h4);
        @(negedge clk);
        core_set(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        #1;
        chk("c2_rvalid", 32'(core_rvalid), 32'd1);
        chk("c2_rdata", core_rdata, 32'hA000_0001);
        chk("c2_dma_rvalid", 32'(dma_rvalid), 32'd0);

        // 3: contention, pattern C,C,C,C,D repeating
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            core_set(1'b1, 1'b0, 32'h1008, 32'h0, 4'b0010);
            dma_set(1'b1, 1'b0, 32'h100C, 32'h0, 4'b0010);
            #1;
            exp_d = (i % 5 == 4);
            chk($sformatf("cont%0d_core_gnt", i),
                32'(core_gnt), 32'(!exp_d));
            chk($sformatf("cont%0d_dma_gnt", i),
                32'(dma_gnt), 32'(exp_d));
            chk($sformatf("cont%0d_stall", i),
                32'(core_stall), 32'(exp_d));
            chk($sformatf("cont%0d_addr", i),
                mem_addr, exp_d ? 32'h100C : 32'h1008);
            chk($sformatf("cont%0d_crv", i),
                32'(core_rvalid), 32'(prev == 1));
            chk($sformatf("cont%0d_drv", i),
                32'(dma_rvalid), 32'(prev == 2));
            if (prev == 2)
                chk($sformatf("cont%0d_drdata", i),
                    dma_rdata, 32'hA000_0003);
            prev = exp_d ? 2 : 1;
        end

        // 4: DMA store alone, then core reads it back
        @(negedge clk);
        core_set(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        dma_set(1'b1, 1'b1, 32'h1010, 32'hDEAD_BEEF, 4'b0010);
        #1;
        chk("st_dma_gnt", 32'(dma_gnt), 32'd1);
        chk("st_memwrite", 32'(mem_memwrite), 32'd1);
        chk("st_memread", 32'(mem_memread), 32'd0);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_addr", mem_addr, 32'h1010);
        chk("st_starve", 32'(dut.starve_cnt), 32'd0);
        @(negedge clk);
        dma_set(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        core_set(1'b1, 1'b0, 32'h1010, 32'h0, 4'b0010);
        #1;
        chk("st_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("raw_core_gnt", 32'(core_gnt), 32'd1);
        @(negedge clk);
        core_set(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        #1;
        chk("raw_rvalid", 32'(core_rvalid), 32'd1);
        chk("raw_rdata", core_rdata, 32'hDEAD_BEEF);
        chk("raw_dma_rvalid", 32'(dma_rvalid), 32'd0);

        // LED store passes through
        @(negedge clk);
        core_set(1'b1, 1'b1, 32'h2000, 32'h0000_00A5, 4'b0010);
        #1;
        chk("led_addr", mem_addr, 32'h2000);
        chk("led_wdata", mem_wdata, 32'h0000_00A5);
        chk("led_memwrite", 32'(mem_memwrite), 32'd1);

        // 5: core load then DMA load, pipelined
        @(negedge clk);
        core_set(1'b1, 1'b0, 32'h1004, 32'h0, 4'b0010);
        #1;
        chk("pl_c_gnt", 32'(core_gnt), 32'd1);
        chk("pl0_crv", 32'(core_rvalid), 32'd0);
        @(negedge clk);
        core_set(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        dma_set(1'b1, 1'b0, 32'h100C, 32'h0, 4'b0010);
        #1;
        chk("pl_d_gnt", 32'(dma_gnt), 32'd1);
        chk("pl1_crv", 32'(core_rvalid), 32'd1);
        chk("pl1_crdata", core_rdata, 32'hA000_0001);
        chk("pl1_drv", 32'(dma_rvalid), 32'd0);
        chk("pl1_drdata", dma_rdata, 32'h0);
        @(negedge clk);
        dma_set(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        #1;
        chk("pl2_drv", 32'(dma_rvalid), 32'd1);
        chk("pl2_drdata", dma_rdata, 32'hA000_0003);
        chk("pl2_crv", 32'(core_rvalid), 32'd0);
        chk("pl2_crdata", core_rdata, 32'h0);

        // 6: reset pulse between grant and return
        @(negedge clk);
        core_set(1'b1, 1'b0, 32'h1008, 32'h0, 4'b0010);
        dma_set(1'b1, 1'b0, 32'h100C, 32'h0, 4'b0010);
        @(negedge clk);
        #1;
        chk("mr_starve_pre", 32'(dut.starve_cnt), 32'd1);
        @(posedge clk);
        #2;
        chk("mr_rvalid_pre", 32'(core_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_rvalid_async", 32'(core_rvalid), 32'd0);
        chk("mr_starve_clr", 32'(dut.starve_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        core_set(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        dma_set(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
        #1;
        chk("mr_rvalid_rel", 32'(core_rvalid), 32'd0);
        @(negedge clk);
        #1;
        chk("mr_no_replay", 32'(core_rvalid), 32'd0);
        chk("mr_no_replay_d", 32'(dma_rvalid), 32'd0);
        core_set(1'b1, 1'b0, 32'h1008, 32'h0, 4'b0010);
        dma_set(1'b1, 1'b0, 32'h100C, 32'h0, 4'b0010);
        #1;
        chk("mr_cont_core", 32'(core_gnt), 32'd1);
        chk("mr_cont_dma", 32'(dma_gnt), 32'd0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
